inst_decode_stage: RTL and testbench

//  Decode stage directly downstream of the fetch unit's instruction buffer. Pops 32-bit
//  RV64I instructions via the buffer's read-enable, decodes register indices, sign-extended

---
 rtl/inst_decode_stage.sv | 261 ++++++++++++++++++++++++++
 tb/tb_inst_decode_stage.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_decode_stage.sv
// inst_decode_stage: pops RV64I instruction words from the fetch buffer, decodes
// register indices, immediate and functional-unit class, and presents them to
// rename/issue from a small circular queue behind a valid/ready handshake.
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN (illegal-encoding detection).
module inst_decode_stage #(
    parameter int QDEPTH = 2,
    parameter int PC_W   = 64
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            fifo_empty,
    output logic            fifo_read_en,
    input  logic            ibuffer_instr_valid,
    input  logic [31:0]     ibuffer_inst_out,
    input  logic [PC_W-1:0] ibuffer_pc_out,
    input  logic            flush,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [PC_W-1:0] dec_pc,
    output logic [31:0]     dec_inst,
    output logic [4:0]      dec_rs1,
    output logic [4:0]      dec_rs2,
    output logic [4:0]      dec_rd,
    output logic            dec_rd_wen,
    output logic [63:0]     dec_imm,
    output logic [2:0]      dec_fu_type,
    output logic            dec_illegal
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    localparam logic [2:0] FU_ALU = 3'd0;
    localparam logic [2:0] FU_BRU = 3'd1;
    localparam logic [2:0] FU_LD  = 3'd2;
    localparam logic [2:0] FU_ST  = 3'd3;
    localparam logic [2:0] FU_MUL = 3'd4;
    localparam logic [2:0] FU_SYS = 3'd5;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_OP32     = 5'b01110;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [63:0] imm;
        logic [2:0]  fu;
        logic        illegal;
    } dec_t;

`ifdef DECODE_ILLEGAL_CHECK_EN
    // Reserved funct3/funct7 combinations in the integer register/immediate groups.
    function automatic logic funct_reserved(input logic [4:0] opc, input logic [2:0] f3,
                                            input logic [6:0] f7);
        logic r;
        r = 1'b0;
        case (opc)
            OPC_OP: begin
                case (f7)
                    7'b0000000, 7'b0000001: r = 1'b0;
                    7'b0100000:             r = !(f3 == 3'b000 || f3 == 3'b101);
                    default:                r = 1'b1;
                endcase
            end
            OPC_OP32: begin
                case (f7)
                    7'b0000000: r = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101);
                    7'b0100000: r = !(f3 == 3'b000 || f3 == 3'b101);
                    7'b0000001: r = (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011);
                    default:    r = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                // RV64 shifts carry a 6-bit shamt, so only f7[6:1] is an opcode field
                if (f3 == 3'b001)
                    r = (f7[6:1] != 6'b000000);
                else if (f3 == 3'b101)
                    r = !(f7[6:1] == 6'b000000 || f7[6:1] == 6'b010000);
            end
            OPC_OP_IMM32: begin
                case (f3)
                    3'b000:  r = 1'b0;
                    3'b001:  r = (f7 != 7'b0000000);
                    3'b101:  r = !(f7 == 7'b0000000 || f7 == 7'b0100000);
                    default: r = 1'b1;
                endcase
            end
            default: r = 1'b0;
        endcase
        return r;
    endfunction
`endif

    // Field extraction by major opcode; inst[1:0] is handled by the caller.
    function automatic dec_t decode(input logic [31:2] iw);
        dec_t        d;
        logic        known;
        logic [63:0] imm_i;
        logic [63:0] imm_s;
        logic [63:0] imm_b;
        logic [63:0] imm_u;
        logic [63:0] imm_j;
        imm_i = {{52{iw[31]}}, iw[31:20]};
        imm_s = {{52{iw[31]}}, iw[31:25], iw[11:7]};
        imm_b = {{52{iw[31]}}, iw[7], iw[30:25], iw[11:8], 1'b0};
        imm_u = {{32{iw[31]}}, iw[31:12], 12'b0};
        imm_j = {{44{iw[31]}}, iw[19:12], iw[20], iw[30:21], 1'b0};
        d     = '0;
        d.fu  = FU_ALU;
        known = 1'b1;
        case (iw[6:2])
            OPC_LUI, OPC_AUIPC: begin
                d.rd = iw[11:7]; d.imm = imm_u;
            end
            OPC_JAL: begin
                d.rd = iw[11:7]; d.imm = imm_j; d.fu = FU_BRU;
            end
            OPC_JALR: begin
                d.rs1 = iw[19:15]; d.rd = iw[11:7]; d.imm = imm_i; d.fu = FU_BRU;
            end
            OPC_LOAD: begin
                d.rs1 = iw[19:15]; d.rd = iw[11:7]; d.imm = imm_i; d.fu = FU_LD;
            end
            OPC_OP_IMM, OPC_OP_IMM32: begin
                d.rs1 = iw[19:15]; d.rd = iw[11:7]; d.imm = imm_i;
            end
            OPC_STORE: begin
                d.rs1 = iw[19:15]; d.rs2 = iw[24:20]; d.imm = imm_s; d.fu = FU_ST;
            end
            OPC_BRANCH: begin
                d.rs1 = iw[19:15]; d.rs2 = iw[24:20]; d.imm = imm_b; d.fu = FU_BRU;
            end
            OPC_OP, OPC_OP32: begin
                d.rs1 = iw[19:15]; d.rs2 = iw[24:20]; d.rd = iw[11:7];
                d.fu  = (iw[31:25] == 7'b0000001) ? FU_MUL : FU_ALU;
            end
            OPC_SYSTEM: begin
                d.rd = iw[11:7]; d.fu = FU_SYS;
                // CSR*I forms reuse the rs1 field as a zero-extended 5-bit immediate
                if (iw[14]) begin
                    d.imm = {59'b0, iw[19:15]};
                end else begin
                    d.rs1 = iw[19:15]; d.imm = imm_i;
                end
            end
            default: known = 1'b0;
        endcase
        d.rd_wen = (d.rd != 5'd0);
`ifdef DECODE_ILLEGAL_CHECK_EN
        d.illegal = !known || funct_reserved(iw[6:2], iw[14:12], iw[31:25]);
`else
        d.illegal = 1'b0;
        if (!known) d.rd_wen = 1'b0;
`endif
        return d;
    endfunction

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             inflight;
    logic             deq;
    logic             enq;
    logic [CNT_W:0]   occupancy;
    dec_t             enq_dec;
    dec_t             head_dec;

    logic [PC_W-1:0]  pc_mem   [QDEPTH];
    logic [31:0]      inst_mem [QDEPTH];
    dec_t             dec_mem  [QDEPTH];

    assign dec_valid = (count != '0);
    assign deq       = dec_valid && dec_ready;
    assign enq       = inflight && ibuffer_instr_valid;
    // Credit: queued entries plus the outstanding pop, minus what leaves this cycle
    assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(deq);
    assign fifo_read_en = reset_n && !fifo_empty && !flush &&
                          (occupancy < (CNT_W+1)'(QDEPTH));
    assign head_dec  = dec_mem[head];

    // Decode the returning word and apply illegal-encoding overrides.
    always_comb begin
        enq_dec = decode(ibuffer_inst_out[31:2]);
`ifdef DECODE_ILLEGAL_CHECK_EN
        if (ibuffer_inst_out[1:0] != 2'b11) enq_dec.illegal = 1'b1;
        if (enq_dec.illegal) begin
            enq_dec.fu     = FU_SYS;
            enq_dec.rd_wen = 1'b0;
        end
`endif
    end

    // Queue pointers, occupancy and outstanding-pop flag; flush wipes all of it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            inflight <= 1'b0;
        end else if (flush) begin
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_read_en;
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
            if (enq && !deq)
                count <= count + CNT_W'(1);
            else if (!enq && deq)
                count <= count - CNT_W'(1);
        end
    end

    // Entry storage; contents are only observed through the valid-gated outputs.
    always_ff @(posedge clock) begin
        if (enq && !flush) begin
            pc_mem[tail]   <= ibuffer_pc_out;
            inst_mem[tail] <= ibuffer_inst_out;
            dec_mem[tail]  <= enq_dec;
        end
    end

    // Present the head entry, zeroed whenever the queue is empty.
    always_comb begin
        dec_pc      = '0;
        dec_inst    = '0;
        dec_rs1     = '0;
        dec_rs2     = '0;
        dec_rd      = '0;
        dec_rd_wen  = 1'b0;
        dec_imm     = '0;
        dec_fu_type = '0;
        dec_illegal = 1'b0;
        if (dec_valid) begin
            dec_pc      = pc_mem[head];
            dec_inst    = inst_mem[head];
            dec_rs1     = head_dec.rs1;
            dec_rs2     = head_dec.rs2;
            dec_rd      = head_dec.rd;
            dec_rd_wen  = head_dec.rd_wen;
            dec_imm     = head_dec.imm;
            dec_fu_type = head_dec.fu;
            dec_illegal = head_dec.illegal;
        end
    end

endmodule

// File: tb/tb_inst_decode_stage.sv
// Self-checking bench for inst_decode_stage: models the instruction buffer,
// predicts pops and outputs from a queue-level reference model.
module tb_inst_decode_stage;
    localparam int QDEPTH = 2;
    localparam int PC_W   = 64;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            fifo_empty = 1'b1;
    logic            fifo_read_en;
    logic            ibuffer_instr_valid = 1'b0;
    logic [31:0]     ibuffer_inst_out = '0;
    logic [PC_W-1:0] ibuffer_pc_out = '0;
    logic            flush = 1'b0;
    logic            dec_valid;
    logic            dec_ready = 1'b0;
    logic [PC_W-1:0] dec_pc;
    logic [31:0]     dec_inst;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [4:0]      dec_rd;
    logic            dec_rd_wen;
    logic [63:0]     dec_imm;
    logic [2:0]      dec_fu_type;
    logic            dec_illegal;

    always #5 clock = ~clock;

    inst_decode_stage #(.QDEPTH(QDEPTH), .PC_W(PC_W)) dut (
        .clock(clock), .reset_n(reset_n), .fifo_empty(fifo_empty),
        .fifo_read_en(fifo_read_en), .ibuffer_instr_valid(ibuffer_instr_valid),
        .ibuffer_inst_out(ibuffer_inst_out), .ibuffer_pc_out(ibuffer_pc_out),
        .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_inst(dec_inst), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rd(dec_rd), .dec_rd_wen(dec_rd_wen), .dec_imm(dec_imm),
        .dec_fu_type(dec_fu_type), .dec_illegal(dec_illegal)
    );

    typedef struct { logic [63:0] pc; logic [31:0] inst; } item_t;
    typedef struct {
        logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd; logic wen;
        logic [63:0] imm; logic [2:0] fu; logic ill;
    } exp_t;

    int errors = 0;
    int checks = 0;
    item_t ibuf[$];
    item_t expq[$];
    logic  pend = 1'b0;
    item_t pend_item;
    int    pops = 0;
    int    delivered = 0;
    logic [63:0] next_pc = 64'h8000_0000;
    // observations captured at the sampling edge of the last cycle
    logic        obs_vld, obs_rd, obs_del, obs_wen, obs_ill;
    logic [63:0] obs_pc, obs_imm;
    logic [31:0] obs_inst;
    logic [4:0]  obs_rdi;
    logic [2:0]  obs_fu;

    // Reference decoder built from the RV64I format tables with plain arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] inst);
        exp_t e;
        longint vi, vs, vb, vu, vj;
        vi = longint'(inst[31:20]) - (inst[31] ? 4096 : 0);
        vs = longint'(inst[31:25]) * 32 + longint'(inst[11:7]) - (inst[31] ? 4096 : 0);
        vb = longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2
             - (inst[31] ? 4096 : 0);
        vu = longint'(inst[31:12]) * 4096 - (inst[31] ? 64'sh1_0000_0000 : 0);
        vj = longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2
             - (inst[31] ? 1048576 : 0);
        e = '{rs1: 0, rs2: 0, rd: 0, wen: 0, imm: 0, fu: 0, ill: 0};
        case (inst[6:2])
            5'b01101, 5'b00101: begin e.rd = inst[11:7]; e.imm = vu; end
            5'b11011: begin e.rd = inst[11:7]; e.imm = vj; e.fu = 1; end
            5'b11001: begin e.rs1 = inst[19:15]; e.rd = inst[11:7]; e.imm = vi; e.fu = 1; end
            5'b00000: begin e.rs1 = inst[19:15]; e.rd = inst[11:7]; e.imm = vi; e.fu = 2; end
            5'b00100, 5'b00110: begin e.rs1 = inst[19:15]; e.rd = inst[11:7]; e.imm = vi; end
            5'b01000: begin e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.imm = vs; e.fu = 3; end
            5'b11000: begin e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.imm = vb; e.fu = 1; end
            5'b01100, 5'b01110: begin
                e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7];
                e.fu = (inst[31:25] == 7'd1) ? 3'd4 : 3'd0;
            end
            5'b11100: begin
                e.rd = inst[11:7]; e.fu = 5;
                if (inst[14]) e.imm = 64'(inst[19:15]);
                else begin e.rs1 = inst[19:15]; e.imm = vi; end
            end
            default: e.ill = 1'b1;
        endcase
        e.wen = (e.rd != 0) && !e.ill;
`ifdef DECODE_ILLEGAL_CHECK_EN
        if (inst[1:0] != 2'b11) e.ill = 1'b1;
        if (e.ill) begin e.fu = 5; e.wen = 1'b0; end
`else
        e.ill = 1'b0;
`endif
        return e;
    endfunction

    // Random legal instruction from the supported opcode groups.
    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        logic [4:0]  opcs [11] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b00000,
                                   5'b00100, 5'b00110, 5'b01000, 5'b11000, 5'b01100, 5'b11100};
        logic [4:0]  op;
        op = opcs[$urandom_range(0, 10)];
        w  = $urandom;
        w[6:0] = {op, 2'b11};
        if (op == 5'b00100 && w[13:12] == 2'b01) w[12] = 1'b0;
        if (op == 5'b00110) w[14:12] = 3'b000;
        if (op == 5'b01100) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'd1 : 7'd0;
        return w;
    endfunction

    function automatic void push_item(input logic [31:0] w);
        item_t it;
        it.pc = next_pc; it.inst = w;
        next_pc = next_pc + 4;
        ibuf.push_back(it);
    endfunction

    // One clock cycle: drive inputs, sample and check at negedge, advance the model.
    task automatic cyc(input logic rdy, input logic fl, input logic stale, input string tag);
        logic dq, erd;
        exp_t e;
        logic [179:0] got, want;
        dec_ready = rdy; flush = fl; fifo_empty = (ibuf.size() == 0);
        ibuffer_instr_valid = pend | stale;
        if (pend) begin
            ibuffer_inst_out = pend_item.inst; ibuffer_pc_out = pend_item.pc;
        end else begin
            ibuffer_inst_out = $urandom; ibuffer_pc_out = {$urandom, $urandom};
        end
        @(negedge clock);
        dq  = (expq.size() != 0) && rdy;
        erd = (ibuf.size() != 0) && !fl && ((expq.size() + int'(pend) - int'(dq)) < QDEPTH);
        checks++;
        if (fifo_read_en !== erd) begin
            errors++;
            $display("FAIL %s rd_en: got %b want %b", tag, fifo_read_en, erd);
        end
        checks++;
        if (dec_valid !== (expq.size() != 0)) begin
            errors++;
            $display("FAIL %s dec_valid: got %b want %b", tag, dec_valid, expq.size() != 0);
        end
        got = {dec_pc, dec_inst, dec_rs1, dec_rs2, dec_rd, dec_rd_wen, dec_imm, dec_fu_type, dec_illegal};
        if (expq.size() != 0) begin
            e = ref_decode(expq[0].inst);
            want = {expq[0].pc, expq[0].inst, e.rs1, e.rs2, e.rd, e.wen, e.imm, e.fu, e.ill};
        end else begin
            want = '0;
        end
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s head fields: got %h want %h", tag, got, want);
        end
        obs_vld = dec_valid; obs_rd = fifo_read_en; obs_del = dec_valid && rdy;
        obs_pc = dec_pc; obs_inst = dec_inst; obs_imm = dec_imm; obs_rdi = dec_rd;
        obs_fu = dec_fu_type; obs_wen = dec_rd_wen; obs_ill = dec_illegal;
        if (obs_del) delivered++;
        if (fl) begin
            expq.delete();
            ibuf.delete();
        end else begin
            if (dq) void'(expq.pop_front());
            if (pend) expq.push_back(pend_item);
        end
        if (fifo_read_en === 1'b1 && ibuf.size() != 0) begin
            pend_item = ibuf.pop_front(); pend = 1'b1; pops++;
        end else begin
            pend = 1'b0;
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        fifo_empty = 1'b0; dec_ready = 1'b1; flush = 1'b0; ibuffer_instr_valid = 1'b0;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (fifo_read_en !== 1'b0) begin errors++; $display("FAIL reset rd_en: got %b want 0", fifo_read_en); end
            checks++;
            if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset dec_valid: got %b want 0", dec_valid); end
            checks++;
            if ({dec_pc, dec_inst, dec_rs1, dec_rs2, dec_rd, dec_rd_wen, dec_imm, dec_fu_type, dec_illegal} !== '0) begin
                errors++; $display("FAIL reset fields: got pc=%h imm=%h fu=%0d want all 0", dec_pc, dec_imm, dec_fu_type);
            end
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_stream();
        int first_pop = -1, first_vld = -1, n0;
        next_pc = 64'h8000_0000;
        push_item(32'h0050_0093);  // addi x1,x0,5
        push_item(32'h0060_0113);  // addi x2,x0,6
        push_item(32'h0020_81B3);  // add  x3,x1,x2
        push_item(32'h0220_8233);  // mul  x4,x1,x2
        n0 = delivered;
        for (int c = 0; c < 9; c++) begin
            cyc(1'b1, 1'b0, 1'b0, "stream");
            if (obs_rd && first_pop < 0) first_pop = c;
            if (obs_vld && first_vld < 0) begin
                first_vld = c;
                checks++;
                if (obs_imm !== 64'd5 || obs_rdi !== 5'd1 || obs_fu !== 3'd0 || obs_pc !== 64'h8000_0000) begin
                    errors++;
                    $display("FAIL stream first: got imm=%0d rd=%0d fu=%0d pc=%h want 5 1 0 80000000", obs_imm, obs_rdi, obs_fu, obs_pc);
                end
            end
        end
        checks++;
        if (first_vld - first_pop != 2) begin
            errors++; $display("FAIL stream latency: got %0d want 2", first_vld - first_pop);
        end
        checks++;
        if (delivered - n0 != 4) begin
            errors++; $display("FAIL stream count: got %0d want 4", delivered - n0);
        end
    endtask

    task automatic test_backpressure();
        int p0, n0;
        logic [63:0] held_pc;
        logic [31:0] held_inst;
        for (int i = 0; i < 6; i++) push_item(gen_inst());
        p0 = pops; n0 = delivered;
        held_pc = '0; held_inst = '0;
        for (int c = 0; c < 6; c++) begin
            cyc(1'b0, 1'b0, 1'b0, "bp_hold");
            if (c == 2) begin held_pc = obs_pc; held_inst = obs_inst; end
        end
        checks++;
        if (pops - p0 != 2) begin errors++; $display("FAIL bp pops: got %0d want 2", pops - p0); end
        checks++;
        if (obs_pc !== held_pc || obs_inst !== held_inst || obs_vld !== 1'b1) begin
            errors++; $display("FAIL bp head stable: got %h/%h want %h/%h", obs_pc, obs_inst, held_pc, held_inst);
        end
        for (int c = 0; c < 14; c++) cyc(1'b1, 1'b0, 1'b0, "bp_drain");
        checks++;
        if (delivered - n0 != 6) begin errors++; $display("FAIL bp delivered: got %0d want 6", delivered - n0); end
    endtask

    task automatic test_flush();
        int n0;
        for (int i = 0; i < 4; i++) push_item(gen_inst());
        cyc(1'b0, 1'b0, 1'b0, "fl_fill");
        cyc(1'b0, 1'b0, 1'b0, "fl_fill");
        cyc(1'b0, 1'b1, 1'b0, "fl_flush");
        next_pc = 64'h8000_1000;
        push_item(32'h0010_0293);  // addi x5,x0,1
        n0 = delivered;
        cyc(1'b1, 1'b0, 1'b1, "fl_after");
        checks++;
        if (obs_vld !== 1'b0) begin errors++; $display("FAIL flush valid: got %b want 0", obs_vld); end
        for (int c = 0; c < 5; c++) begin
            cyc(1'b1, 1'b0, 1'b0, "fl_new");
            if (obs_del && delivered - n0 == 1) begin
                checks++;
                if (obs_pc !== 64'h8000_1000) begin
                    errors++; $display("FAIL flush newpc: got %h want 8000000000001000", obs_pc);
                end
            end
        end
        checks++;
        if (delivered - n0 != 1) begin errors++; $display("FAIL flush count: got %0d want 1", delivered - n0); end
    endtask

    task automatic test_immediates();
        logic [63:0] imm_t [3] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'd16, 64'hFFFF_FFFF_FFFF_F000};
        logic [2:0]  fu_t  [3] = '{3'd1, 3'd3, 3'd0};
        logic        wen_t [3] = '{1'b0, 1'b0, 1'b1};
        int k = 0;
        push_item(32'hFE20_8CE3);  // beq x1,x2,-8
        push_item(32'h0051_3823);  // sd  x5,16(x2)
        push_item(32'hFFFF_F3B7);  // lui x7,0xFFFFF
        for (int c = 0; c < 8; c++) begin
            cyc(1'b1, 1'b0, 1'b0, "imm");
            if (obs_del && k < 3) begin
                checks++;
                if (obs_imm !== imm_t[k] || obs_fu !== fu_t[k] || obs_wen !== wen_t[k]) begin
                    errors++;
                    $display("FAIL imm[%0d]: got imm=%h fu=%0d wen=%b want imm=%h fu=%0d wen=%b",
                             k, obs_imm, obs_fu, obs_wen, imm_t[k], fu_t[k], wen_t[k]);
                end
                k++;
            end
        end
        checks++;
        if (k != 3) begin errors++; $display("FAIL imm count: got %0d want 3", k); end
    endtask

    task automatic test_illegal();
        int k = 0;
        push_item(32'h0000_0000);
        for (int c = 0; c < 5; c++) begin
            cyc(1'b1, 1'b0, 1'b0, "illegal");
            if (obs_del) begin
                k++;
                checks++;
`ifdef DECODE_ILLEGAL_CHECK_EN
                if (obs_ill !== 1'b1 || obs_fu !== 3'd5) begin
                    errors++; $display("FAIL illegal: got ill=%b fu=%0d want 1 5", obs_ill, obs_fu);
                end
`else
                if (obs_ill !== 1'b0) begin
                    errors++; $display("FAIL illegal: got ill=%b want 0", obs_ill);
                end
`endif
            end
        end
        checks++;
        if (k != 1) begin errors++; $display("FAIL illegal count: got %0d want 1", k); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (ibuf.size() < 4 && $urandom_range(0, 1) == 1) push_item(gen_inst());
            cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
                (!pend && $urandom_range(0, 7) == 0), "random");
        end
        for (int c = 0; c < 12; c++) cyc(1'b1, 1'b0, 1'b0, "rand_drain");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) push_item(gen_inst());
        for (int c = 0; c < 3; c++) cyc(1'b0, 1'b0, 1'b0, "rst_fill");
        fifo_empty = (ibuf.size() == 0);
        reset_n = 1'b0;
        #2;
        checks++;
        if (dec_valid !== 1'b0 || fifo_read_en !== 1'b0) begin
            errors++; $display("FAIL mid reset: got valid=%b rd_en=%b want 0 0", dec_valid, fifo_read_en);
        end
        expq.delete(); pend = 1'b0; ibuffer_instr_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        for (int c = 0; c < 10; c++) cyc(1'b1, 1'b0, 1'b0, "post_reset");
        checks++;
        if (ibuf.size() != 0 || expq.size() != 0 || obs_vld !== 1'b0) begin
            errors++; $display("FAIL post reset drain: got ibuf=%0d q=%0d valid=%b want 0 0 0", ibuf.size(), expq.size(), obs_vld);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_immediates();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
